// File: rtl/ram_if.sv
// Data-RAM port bundle: the engine drives the request side (master);
// the RAM returns combinational read data (slave).
interface ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] MemData_in;

  modport master (
    output MemWrite,
    output MemRead,
    output Address,
    output WriteData,
    input  MemData_in
  );

  modport slave (
    input  MemWrite,
    input  MemRead,
    input  Address,
    input  WriteData,
    output MemData_in
  );
endinterface

// File: rtl/ram_copy_engine.sv
// Block FILL and overlap-safe COPY (memmove) engine driving a single data-RAM port.
// One word per cycle for FILL; a read cycle followed by a write cycle per word for COPY.
module ram_copy_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  ram_if.master             mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic              OP_FILL = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic              desc_q, desc_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;

  // End addresses are one bit wider so an overflowing request is still caught.
  logic [ADDR_W:0] dst_end;
  logic [ADDR_W:0] src_end;
  logic            range_bad;

  assign dst_end   = {1'b0, dst_addr} + {1'b0, length};
  assign src_end   = {1'b0, src_addr} + {1'b0, length};
  assign range_bad = (dst_end > DEPTH_W) || ((op != OP_FILL) && (src_end > DEPTH_W));

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      desc_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      desc_q  <= desc_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal gets a hold/default value before the case statement, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    desc_d  = desc_q;
    src_d   = src_q;
    dst_d   = dst_q;
    off_d   = off_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = length;
          fill_d = fill_value;
          // Only a COPY whose destination lies above its source must walk downwards.
          desc_d = (op != OP_FILL) && (dst_addr > src_addr);
          off_d  = ((op != OP_FILL) && (dst_addr > src_addr)) ? (length - ONE) : '0;
          if (range_bad)            state_d = S_ERR;
          else if (length == '0)    state_d = S_DONE;
          else if (op == OP_FILL)   state_d = S_WR;
          else                      state_d = S_RD;
        end
      end
      S_RD: begin
        data_d  = mem.MemData_in;
        state_d = S_WR;
      end
      S_WR: begin
        if (rem_q > ONE) begin
          rem_d   = rem_q - ONE;
          off_d   = desc_q ? (off_q - ONE) : (off_q + ONE);
          state_d = (op_q == OP_FILL) ? S_WR : S_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode purely from state and registers, so reset clears them at once.
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    error         = (state_q == S_ERR);
    mem.MemRead   = (state_q == S_RD);
    mem.MemWrite  = (state_q == S_WR);
    mem.Address   = '0;
    mem.WriteData = '0;
    if (state_q == S_RD) begin
      mem.Address = src_q + off_q;
    end else if (state_q == S_WR) begin
      mem.Address   = dst_q + off_q;
      mem.WriteData = (op_q == OP_FILL) ? fill_q : data_q;
    end
  end

endmodule
